decoder_rr_arbiter: RTL and testbench

- Four-requester round-robin arbiter that shares one decoded select resource.
- The 2-bit winning index drives a 2:4 decode to produce a one-hot grant bus.
- Sits between the requesting agents and the shared decoder-selected resource.
- Sequences grant, hold, release and a mandatory one-cycle dead gap between owners.

---
 rtl/decoder_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - four-way round-robin arbiter driving a 2:4 decoded one-hot grant
// Optional feature macro: ARB_HOLD_LIMIT_EN (MAX_HOLD forced release and timeout pulse).
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam bit CFG_OK = (MAX_HOLD >= 1) && (MAX_HOLD <= 255) && ((1 << HOLD_W) > MAX_HOLD);

  state_t     state, state_nx;
  logic [1:0] last_ptr, last_nx;
  logic [1:0] idx_nx;
  logic       valid_nx;
  logic       timeout_nx;
  logic [3:0] gnt_nx;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       hold_hit;
  logic       release_now;

  // Search last+1 .. last+4 so the previous owner is always considered last.
  always_comb begin
    winner = last_ptr;
    cand   = last_ptr;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == S_IDLE && (|req)) begin
      hold_cnt <= HOLD_W'(1);
    end else if (state == S_GRANT && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign hold_hit = CFG_OK && (hold_cnt == HOLD_MAX);
`else
  assign hold_hit = 1'b0 & CFG_OK;
`endif

  assign release_now = done[gnt_idx] || !req[gnt_idx] || hold_hit;

  always_comb begin
    state_nx   = state;
    last_nx    = last_ptr;
    idx_nx     = gnt_idx;
    valid_nx   = gnt_valid;
    timeout_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nx = S_GRANT;
          idx_nx   = winner;
          last_nx  = winner;
          valid_nx = 1'b1;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_nx   = S_GAP;
          valid_nx   = 1'b0;
          // A coincident done wins over the hold limit, so no timeout then.
          timeout_nx = hold_hit && !done[gnt_idx];
        end
      end
      S_GAP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        valid_nx = 1'b0;
      end
    endcase
    gnt_nx = valid_nx ? (4'b0001 << idx_nx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_ptr  <= 2'd3;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      gnt       <= 4'b0000;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      last_ptr  <= last_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      gnt       <= gnt_nx;
      timeout   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - vector table, corner sequences and random model check for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

  localparam int MAXH = 8;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] done = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: phase 0=idle 1=owned 2=gap
  int m_phase, m_owner, m_last, m_hold;
  bit m_to;

  decoder_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  typedef struct {
    logic [3:0] r;
    logic [3:0] d;
    logic [3:0] g;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 3; m_hold = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    bit expired;
    m_to = 1'b0;
    if (m_phase == 0) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_phase == 0 && r[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            m_phase = 1;
          end
        end
        m_last = m_owner;
        m_hold = 1;
      end
    end else if (m_phase == 1) begin
      expired = HOLD_ON && (m_hold >= MAXH);
      if (d[m_owner] || !r[m_owner] || expired) begin
        m_phase = 2;
        m_to = expired && !d[m_owner];
      end else begin
        m_hold++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    req = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    done = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_valid"}, gnt_valid, (m_phase == 1));
    check({tag, "_timeout"}, timeout, m_to);
    if (m_phase == 1) check({tag, "_idx"}, gnt_idx, m_owner);
  endtask

  initial begin
    int n;
    int bad;
    logic [3:0] r, d;

    // Hand-derived vectors from reset (last pointer 3): round robin with done in the 2nd held cycle,
    // then a single requester, ignored non-owner done and req drop.
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    tbl[2]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    tbl[6]  = '{4'b1111, 4'b0010, 4'b0000, 2'd0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
    tbl[10] = '{4'b1111, 4'b0100, 4'b0000, 2'd0};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    tbl[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
    tbl[13] = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
    tbl[14] = '{4'b1111, 4'b1000, 4'b0000, 2'd0};
    tbl[15] = '{4'b1111, 4'b0000, 4'b0000, 2'd0};
    tbl[16] = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[18] = '{4'b0100, 4'b0000, 4'b0000, 2'd0};
    tbl[19] = '{4'b0100, 4'b0000, 4'b0100, 2'd2};
    tbl[20] = '{4'b0100, 4'b1011, 4'b0100, 2'd2};
    tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[22] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};

    do_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_idx", gnt_idx, 2'd0);
    check("rst_valid", gnt_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r, tbl[i].d);
      check($sformatf("vec%0d_gnt", i), gnt, tbl[i].g);
      check($sformatf("vec%0d_valid", i), gnt_valid, (tbl[i].g != 4'b0000));
      check($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      if (tbl[i].g != 4'b0000) check($sformatf("vec%0d_idx", i), gnt_idx, tbl[i].idx);
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Hold limit without done: MAXH owned cycles, timeout in gap, idle, re-grant.
    do_reset();
    drive(4'b0001, 4'b0000);
    n = 0;
    while (gnt == 4'b0001 && n < 40) begin
      n++;
      drive(4'b0001, 4'b0000);
    end
    check("hold_len", n, MAXH);
    check("hold_timeout", timeout, 1'b1);
    check("hold_gap_gnt", gnt, 4'b0000);
    drive(4'b0001, 4'b0000);
    check("hold_idle_timeout", timeout, 1'b0);
    check("hold_idle_gnt", gnt, 4'b0000);
    drive(4'b0001, 4'b0000);
    check("hold_regrant", gnt, 4'b0001);

    // done in the last allowed hold cycle beats the timeout.
    do_reset();
    for (int i = 0; i < MAXH; i++) drive(4'b0001, 4'b0000);
    check("donehit_gnt_before", gnt, 4'b0001);
    drive(4'b0001, 4'b0001);
    check("donehit_gnt", gnt, 4'b0000);
    check("donehit_timeout", timeout, 1'b0);
`else
    // No hold limit: the grant persists indefinitely.
    do_reset();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(4'b0001, 4'b0000);
      if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
    end
    check("nolimit_bad_cycles", bad, 0);
    check("nolimit_gnt_end", gnt, 4'b0001);
`endif

    // Non-owner done ignored, then asynchronous reset mid-grant.
    do_reset();
    drive(4'b0010, 4'b0000);
    check("g1_gnt", gnt, 4'b0010);
    drive(4'b0010, 4'b1100);
    check("g1_ignore_done", gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 4'b0000);
    check("async_rst_valid", gnt_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(4'b1010, 4'b0000);
    check("post_rst_gnt", gnt, 4'b0010);
    check("post_rst_idx", gnt_idx, 2'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++) begin
        r[b] = ($urandom_range(0, 9) != 0);
        d[b] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 15) == 0) r = 4'b0000;
      drive(r, d);
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
